mem_share_ctrl: RTL

- Controller for a single-port synchronous memory (default 16 x 16-bit) that two requesters share.
- Controls memory initialisation: after reset, and on request, it writes INIT_VAL to every word.
- After initialisation, grants requesters access to the memory port in round-robin order, one access per cycle.
- Read data returns one cycle after the grant.

---
 rtl/mem_share_ctrl_pkg.sv | 13 +
 rtl/mem_share_ctrl_rr_arb2.sv | 38 +++
 rtl/mem_share_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_share_ctrl_pkg.sv
// Shared definitions for the memory-share controller.
//   state_t : controller states (init sweep / serving requesters)
//   NREQ    : number of requesters sharing the memory port
package mem_share_ctrl_pkg;

  localparam int unsigned NREQ = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/mem_share_ctrl_rr_arb2.sv
// 2-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request per requester
//   accept     : the current grant was taken (handshake)
//   gnt        : one-hot combinational grant
// rr_last remembers the last winner; on a tie the other requester wins.
// It resets to 1 so requester 0 wins the first tie.
module rr_arb2
  import mem_share_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_share_ctrl.sv
// Controller for a single-port synchronous memory shared by two requesters.
// After reset (or init_start) it sweeps INIT_VAL into every word, then
// grants the port round-robin, one access per cycle.
//   clk, rst_n              : clock, asynchronous active-low reset
//   init_start              : pulse, (re)start a full init sweep
//   init_busy / init_done   : sweep running / pulse after the last init write
//   req_valid/we/addrN/wdataN, req_ready : requester handshake
//   rsp_valid / rsp_rdata   : read response, one cycle after a granted read
//   mem_en/we/addr/wdata, mem_rdata      : memory port (1-cycle read latency)
module mem_share_ctrl
  import mem_share_ctrl_pkg::*;
#(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   AW       = 4,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_start,
  output logic          init_busy,
  output logic          init_done,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [1:0]    rsp_valid_q;
  logic [1:0]    arb_req;
  logic [1:0]    gnt;
  logic          accept;

  // Requests reach the arbiter only while serving and not re-initialising,
  // so a gated-off cycle neither grants nor advances rr_last.
  assign arb_req = ((state_q == ST_SERVE) && !init_start) ? req_valid : 2'b00;
  assign accept  = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .accept (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_start) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_SERVE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SERVE: begin
        if (init_start) begin
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = req_addr0;
    mem_wdata = req_wdata0;
    if (state_q == ST_INIT) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = INIT_VAL;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = req_we[1];
      mem_addr  = req_addr1;
      mem_wdata = req_wdata1;
    end else if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = req_we[0];
      mem_addr  = req_addr0;
      mem_wdata = req_wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rsp_valid_q <= gnt & ~req_we;
    end
  end

  assign init_busy = (state_q == ST_INIT);
  assign init_done = done_q;
  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = mem_rdata;

endmodule
